lc3b_mem_responder: RTL and testbench

//  Memory-side responder for the datapath's mem_read/mem_write control outputs (LDR/STR/fetch).

---
 rtl/lc3b_mem_responder_if.sv | 27 ++
 rtl/lc3b_mem_responder.sv | 140 ++++++++++++++
 tb/tb_lc3b_mem_responder.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/lc3b_mem_responder_if.sv
// Request/response bus between the LC-3b datapath (master) and its memory (slave).
// ADDR_W must match the ADDR_W of the lc3b_mem_responder attached to it.
interface lc3b_mem_responder_if #(
    parameter int ADDR_W = 16
);
    // Handshake: the master raises mem_read or mem_write and holds it, with address/data/byte
    // enables stable, until the slave pulses mem_resp for one cycle; mem_rdata is valid only in
    // that cycle, and a request still high in the following cycle starts a new transaction.
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [15:0]       mem_wdata;
    logic [1:0]        mem_byte_enable;
    logic              mem_resp;
    logic [15:0]       mem_rdata;
    logic              proto_err;

    modport master (
        output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        input  mem_resp, mem_rdata, proto_err
    );

    modport slave (
        input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        output mem_resp, mem_rdata, proto_err
    );
endinterface

// File: rtl/lc3b_mem_responder.sv
// Fixed-latency word-organised 16-bit RAM answering LC-3b mem_read/mem_write with a mem_resp pulse.
// Optional LC3B_MEM_PROTO_CHECK_EN builds a sticky proto_err monitor of the request protocol.
module lc3b_mem_responder #(
    parameter int ADDR_W  = 16,
    parameter int LATENCY = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    lc3b_mem_responder_if.slave  mem_bus,
    output logic [1:0]           o_dbg_state
);
    localparam int          WA_W  = ADDR_W - 1;
    localparam int          WORDS = 2 ** WA_W;
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [3:0]      r_cnt;
    logic [3:0]      w_cnt_next;
    logic [WA_W-1:0] r_waddr;
    logic [15:0]     r_wdata;
    logic [1:0]      r_be;
    logic            r_is_write;
    logic [15:0]     r_rdata;
    logic [15:0]     r_ram [WORDS];

    logic            w_req;
    logic            w_accept;
    logic            w_next_is_write;
    logic [WA_W-1:0] w_rd_word;
    logic            w_load_rdata;

    assign w_req = mem_bus.mem_read | mem_bus.mem_write;

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_accept   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_accept   = 1'b1;
                    w_cnt_next = CNT_LOAD;
                    w_next     = (LATENCY == 1) ? ST_RESP : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (r_cnt <= 4'd1) begin
                    w_next     = ST_RESP;
                    w_cnt_next = 4'd0;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            ST_RESP: begin
                w_next     = ST_IDLE;
                w_cnt_next = 4'd0;
            end
            default: begin
                w_next     = ST_IDLE;
                w_cnt_next = 4'd0;
            end
        endcase
    end

    // Read data is registered on the edge that enters RESP, so it is valid for exactly that cycle
    // and zero otherwise; a write in flight can never collide since writes commit only from RESP.
    assign w_next_is_write = w_accept ? mem_bus.mem_write : r_is_write;
    assign w_rd_word       = w_accept ? mem_bus.mem_address[ADDR_W-1:1] : r_waddr;
    assign w_load_rdata    = (w_next == ST_RESP) && !w_next_is_write;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_waddr    <= '0;
            r_wdata    <= 16'h0000;
            r_be       <= 2'b00;
            r_is_write <= 1'b0;
            r_rdata    <= 16'h0000;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_waddr    <= mem_bus.mem_address[ADDR_W-1:1];
                r_wdata    <= mem_bus.mem_wdata;
                r_be       <= mem_bus.mem_byte_enable;
                r_is_write <= mem_bus.mem_write;
            end
            r_rdata <= w_load_rdata ? r_ram[w_rd_word] : 16'h0000;
        end
    end

    // RAM is never cleared; a reset during RESP suppresses the pending write.
    always_ff @(posedge clk) begin
        if (!rst && (r_state == ST_RESP) && r_is_write) begin
            if (r_be[0]) r_ram[r_waddr][7:0]  <= r_wdata[7:0];
            if (r_be[1]) r_ram[r_waddr][15:8] <= r_wdata[15:8];
        end
    end

    assign mem_bus.mem_resp  = (r_state == ST_RESP);
    assign mem_bus.mem_rdata = r_rdata;
    assign o_dbg_state       = r_state;

`ifdef LC3B_MEM_PROTO_CHECK_EN
    logic r_proto_err;
    logic r_addr_b0;
    logic w_drop;
    logic w_viol;

    // Only the request line that was latched as the transaction type must stay high.
    assign w_drop = r_is_write ? !mem_bus.mem_write : !mem_bus.mem_read;
    assign w_viol = (w_accept && mem_bus.mem_read && mem_bus.mem_write) ||
                    ((r_state == ST_BUSY) &&
                     (w_drop || (mem_bus.mem_address != {r_waddr, r_addr_b0})));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_proto_err <= 1'b0;
            r_addr_b0   <= 1'b0;
        end else begin
            if (w_accept) r_addr_b0 <= mem_bus.mem_address[0];
            if (w_viol)   r_proto_err <= 1'b1;
        end
    end

    assign mem_bus.proto_err = r_proto_err;
`else
    logic w_unused_addr_b0;
    assign w_unused_addr_b0  = mem_bus.mem_address[0];
    assign mem_bus.proto_err = 1'b0;
`endif
endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Randomized self-checking bench for lc3b_mem_responder against a word-array memory model.
module tb_lc3b_mem_responder;
    localparam int LAT = 3;
`ifdef LC3B_MEM_PROTO_CHECK_EN
    localparam logic PROTO = 1'b1;
`else
    localparam logic PROTO = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;
    int         n_vec;
    int         n_err;
    logic [15:0] model_mem [int];
    logic [15:0] last_rdata;

    lc3b_mem_responder_if #(.ADDR_W(16)) bus ();

    lc3b_mem_responder #(.ADDR_W(16), .LATENCY(LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_bus     (bus),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_bus();
        bus.mem_read        = 1'b0;
        bus.mem_write       = 1'b0;
        bus.mem_address     = 16'h0000;
        bus.mem_wdata       = 16'h0000;
        bus.mem_byte_enable = 2'b00;
    endtask

    task automatic do_reset();
        idle_bus();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic model_write(input logic [15:0] addr, input logic [15:0] d, input logic [1:0] be);
        int w;
        logic [15:0] cur;
        w   = int'(addr[15:1]);
        cur = model_mem.exists(w) ? model_mem[w] : 16'h0000;
        if (be[0]) cur[7:0]  = d[7:0];
        if (be[1]) cur[15:8] = d[15:8];
        model_mem[w] = cur;
    endtask

    function automatic logic [15:0] model_read(input logic [15:0] addr);
        int w;
        w = int'(addr[15:1]);
        return model_mem.exists(w) ? model_mem[w] : 16'hxxxx;
    endfunction

    // Called #1 after an edge with the responder idle; returns #1 after the idle cycle that follows.
    task automatic do_xfer(input logic rd, input logic wr, input logic [15:0] addr,
                           input logic [15:0] wd, input logic [1:0] be, input string tag);
        int   edges;
        logic seen;
        bus.mem_read        = rd;
        bus.mem_write       = wr;
        bus.mem_address     = addr;
        bus.mem_wdata       = wd;
        bus.mem_byte_enable = be;
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 20) begin
            @(posedge clk);
            #1 edges++;
            if (bus.mem_resp) seen = 1'b1;
        end
        check({tag, "_latency"}, 32'(edges), 32'(LAT));
        last_rdata = bus.mem_rdata;
        if (seen) begin
            if (wr) model_write(addr, wd, be);
            else    check({tag, "_rdata"}, {16'h0, bus.mem_rdata}, {16'h0, model_read(addr)});
        end
        idle_bus();
        @(posedge clk);
        #1;
        check({tag, "_resp_low_after"}, {31'h0, bus.mem_resp}, 32'h0);
        check({tag, "_rdata_zero_after"}, {16'h0, bus.mem_rdata}, 32'h0);
    endtask

    initial begin
        int   edges;
        int   r1;
        int   r2;
        logic prev;
        logic any_resp;
        n_vec = 0;
        n_err = 0;
        last_rdata = 16'h0;
        rst = 1'b0;
        idle_bus();
        do_reset();
        check("reset_resp", {31'h0, bus.mem_resp}, 32'h0);
        check("reset_rdata", {16'h0, bus.mem_rdata}, 32'h0);
        check("reset_proto_err", {31'h0, bus.proto_err}, 32'h0);

        // Full write then read, then byte-lane merges
        do_xfer(1'b0, 1'b1, 16'h0040, 16'h1234, 2'b11, "t1_wr");
        do_xfer(1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, "t1_rd");
        check("t1_value", {16'h0, last_rdata}, 32'h1234);
        do_xfer(1'b0, 1'b1, 16'h0040, 16'hABCD, 2'b10, "t2_wr_hi");
        do_xfer(1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, "t2_rd_hi");
        check("t2_value_hi", {16'h0, last_rdata}, 32'hAB34);
        do_xfer(1'b0, 1'b1, 16'h0040, 16'hABCD, 2'b01, "t2_wr_lo");
        do_xfer(1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, "t2_rd_lo");
        check("t2_value_lo", {16'h0, last_rdata}, 32'hABCD);
        do_xfer(1'b1, 1'b0, 16'h0041, 16'h0000, 2'b00, "t3_rd_odd");
        check("t3_value_odd", {16'h0, last_rdata}, 32'hABCD);
        do_xfer(1'b0, 1'b1, 16'h0040, 16'h9999, 2'b00, "t3_wr_be0");
        do_xfer(1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, "t3_rd_be0");
        check("t3_value_be0", {16'h0, last_rdata}, 32'hABCD);

        // Read held high across the response: two transactions, LAT+1 cycles apart
        bus.mem_read    = 1'b1;
        bus.mem_address = 16'h0040;
        edges = 0; r1 = -1; r2 = -1; prev = 1'b0;
        while (r2 < 0 && edges < 40) begin
            @(posedge clk);
            #1 edges++;
            if (bus.mem_resp) begin
                check("t4_no_double_resp", {31'h0, prev}, 32'h0);
                check("t4_rdata", {16'h0, bus.mem_rdata}, 32'hABCD);
                if (r1 < 0) r1 = edges;
                else        r2 = edges;
            end
            prev = bus.mem_resp;
        end
        idle_bus();
        check("t4_first_latency", 32'(r1), 32'(LAT));
        check("t4_gap", 32'(r2 - r1), 32'(LAT + 1));
        @(posedge clk);
        #1 check("t4_resp_low_after", {31'h0, bus.mem_resp}, 32'h0);

        // Reset in the middle of a write aborts it
        do_xfer(1'b0, 1'b1, 16'h0080, 16'h0F0F, 2'b11, "t5_init");
        bus.mem_write       = 1'b1;
        bus.mem_address     = 16'h0080;
        bus.mem_wdata       = 16'h5555;
        bus.mem_byte_enable = 2'b11;
        @(posedge clk);
        #1 rst = 1'b1;
        idle_bus();
        @(posedge clk);
        #1 rst = 1'b0;
        any_resp = 1'b0;
        for (int i = 0; i < 2 * LAT + 2; i++) begin
            if (bus.mem_resp) any_resp = 1'b1;
            @(posedge clk);
            #1;
        end
        check("t5_no_resp", {31'h0, any_resp}, 32'h0);
        do_xfer(1'b1, 1'b0, 16'h0080, 16'h0000, 2'b00, "t5_rd");
        check("t5_old_value", {16'h0, last_rdata}, 32'h0F0F);

        // Address changed mid-BUSY: latched address used, proto_err raised only with the checker
        bus.mem_read    = 1'b1;
        bus.mem_address = 16'h0040;
        @(posedge clk);
        #1 bus.mem_address = 16'h0080;
        edges = 1;
        while (!bus.mem_resp && edges < 20) begin
            @(posedge clk);
            #1 edges++;
        end
        check("t6_latency", 32'(edges), 32'(LAT));
        check("t6_latched_rdata", {16'h0, bus.mem_rdata}, 32'hABCD);
        idle_bus();
        @(posedge clk);
        #1 check("t6_proto_err_set", {31'h0, bus.proto_err}, {31'h0, PROTO});
        do_xfer(1'b1, 1'b0, 16'h0080, 16'h0000, 2'b00, "t6_clean");
        check("t6_proto_err_sticky", {31'h0, bus.proto_err}, {31'h0, PROTO});
        do_reset();
        check("t6_proto_err_cleared", {31'h0, bus.proto_err}, 32'h0);
        // Read and write both high: treated as a write
        do_xfer(1'b1, 1'b1, 16'h0080, 16'h7E57, 2'b11, "t6_both");
        check("t6_both_proto_err", {31'h0, bus.proto_err}, {31'h0, PROTO});
        do_xfer(1'b1, 1'b0, 16'h0080, 16'h0000, 2'b00, "t6_both_rd");
        check("t6_both_value", {16'h0, last_rdata}, 32'h7E57);
        do_reset();

        // Randomized traffic over a small initialised pool of words
        for (int i = 0; i < 8; i++)
            do_xfer(1'b0, 1'b1, 16'h0200 + 16'(2 * i), 16'($urandom), 2'b11, "rnd_init");
        for (int i = 0; i < 150; i++) begin
            logic [15:0] a;
            logic        is_wr;
            a     = 16'h0200 + 16'($urandom_range(0, 15));
            is_wr = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            if (is_wr)
                do_xfer(1'($urandom_range(0, 3) == 0) & ~PROTO, 1'b1, a, 16'($urandom),
                        2'($urandom_range(0, 3)), "rnd_wr");
            else
                do_xfer(1'b1, 1'b0, a, 16'($urandom), 2'($urandom_range(0, 3)), "rnd_rd");
        end
        check("rnd_proto_err_clean", {31'h0, bus.proto_err}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
